// File: rtl/pattern_gen.sv
// Video timing and test-pattern source: parametrised raster, PPC pixels per clock,
// runtime pattern select and start/stop control. Define SCROLL_EN for per-frame horizontal scroll.
module pattern_gen #(
  parameter int H_ACTIVE  = 1920,
  parameter int H_FP      = 88,
  parameter int H_SYNC    = 44,
  parameter int H_BP      = 148,
  parameter int V_ACTIVE  = 1080,
  parameter int V_FP      = 4,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 36,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int PPC       = 1,
  parameter int CHK_SHIFT = 5,
  parameter int CNT_W     = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [23:0]        solid_rgb,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic [24*PPC-1:0]  rgb,
  output logic               sof,
  output logic               busy
);

  localparam logic [CNT_W-1:0] ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HT_M1  = CNT_W'((H_FP + H_SYNC + H_BP + H_ACTIVE) / PPC - 1);
  localparam logic [CNT_W-1:0] HB     = CNT_W'((H_FP + H_SYNC + H_BP) / PPC);
  localparam logic [CNT_W-1:0] HS_ON  = CNT_W'(H_FP / PPC);
  localparam logic [CNT_W-1:0] HS_OFF = CNT_W'((H_FP + H_SYNC) / PPC);
  localparam logic [CNT_W-1:0] VT_M1  = CNT_W'(V_FP + V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VB     = CNT_W'(V_FP + V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] VS_ON  = CNT_W'(V_FP);
  localparam logic [CNT_W-1:0] VS_OFF = CNT_W'(V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] HACT   = CNT_W'(H_ACTIVE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t                state_r;
  logic [CNT_W-1:0]      h_cnt_r;
  logic [CNT_W-1:0]      v_cnt_r;
  logic [1:0]            mode_r;
  logic [23:0]           solid_r;
  logic                  h_last_s;
  logic                  frame_last_s;
  logic                  frame_start_s;
  logic                  active_s;
  logic [CNT_W-1:0]      hx_s;
  logic [CNT_W-1:0]      y_s;
  logic [CNT_W-1:0]      xk_s;
  logic [CNT_W-1:0]      xs_s;
  logic [24*PPC-1:0]     pix_s;
`ifdef SCROLL_EN
  logic [CNT_W-1:0]      off_r;
  logic [CNT_W-1:0]      off_frame_r;
`endif

  // Bars are picked by threshold compares so no divider is needed for BAR_W.
  function automatic logic [23:0] lane_rgb(input logic [CNT_W-1:0] x,
                                           input logic [CNT_W-1:0] y,
                                           input logic [1:0]       md,
                                           input logic [23:0]      solid);
    logic [2:0]       bar;
    logic [CNT_W-1:0] cx;
    logic [23:0]      res;
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x >= CNT_W'(i * (H_ACTIVE / 8))) bar = bar + 3'd1;
      else                                  bar = bar;
    end
    cx = (x >> CHK_SHIFT) ^ (y >> CHK_SHIFT);
    case (md)
      2'd0: begin
        case (bar)
          3'd0:    res = 24'hFFFFFF;
          3'd1:    res = 24'hFFFF00;
          3'd2:    res = 24'h00FFFF;
          3'd3:    res = 24'h00FF00;
          3'd4:    res = 24'hFF00FF;
          3'd5:    res = 24'hFF0000;
          3'd6:    res = 24'h0000FF;
          default: res = 24'h000000;
        endcase
      end
      2'd1:    res = {x[7:0], x[7:0], x[7:0]};
      2'd2:    res = cx[0] ? 24'h000000 : 24'hFFFFFF;
      default: res = solid;
    endcase
    return res;
  endfunction

  assign h_last_s      = (h_cnt_r == HT_M1);
  assign frame_last_s  = h_last_s && (v_cnt_r == VT_M1);
  assign frame_start_s = (state_r == ST_RUN) && (h_cnt_r == ZERO) && (v_cnt_r == ZERO);
  assign active_s      = (h_cnt_r >= HB) && (v_cnt_r >= VB);
  assign hx_s          = h_cnt_r - HB;
  assign y_s           = v_cnt_r - VB;

  // Run control and raster counters; STOP only differs from RUN in that it may end the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      h_cnt_r <= ZERO;
      v_cnt_r <= ZERO;
      busy    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          h_cnt_r <= ZERO;
          v_cnt_r <= ZERO;
          if (en) begin
            state_r <= ST_RUN;
            busy    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        ST_RUN, ST_STOP: begin
          h_cnt_r <= h_last_s ? ZERO : h_cnt_r + ONE;
          if (h_last_s) v_cnt_r <= (v_cnt_r == VT_M1) ? ZERO : v_cnt_r + ONE;
          else          v_cnt_r <= v_cnt_r;
          if (en) begin
            state_r <= ST_RUN;
            busy    <= 1'b1;
          end else if (frame_last_s) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            state_r <= ST_STOP;
            busy    <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          h_cnt_r <= ZERO;
          v_cnt_r <= ZERO;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Frame-start shadow of the runtime pattern controls (and scroll offset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r      <= 2'd0;
      solid_r     <= 24'h000000;
`ifdef SCROLL_EN
      off_r       <= ZERO;
      off_frame_r <= ZERO;
`endif
    end else if (frame_start_s) begin
      mode_r      <= mode;
      solid_r     <= solid_rgb;
`ifdef SCROLL_EN
      off_frame_r <= off_r;
      off_r       <= (off_r == HACT - ONE) ? ZERO : off_r + ONE;
`endif
    end
  end

  // Per-lane pixel colour for the current counter position.
  always_comb begin
    pix_s = {(24*PPC){1'b0}};
    xk_s  = ZERO;
    xs_s  = ZERO;
    for (int k = 0; k < PPC; k++) begin
      xk_s = CNT_W'(32'(hx_s) * PPC + k);
`ifdef SCROLL_EN
      xs_s = xk_s + off_frame_r;
      if (xs_s >= HACT) xs_s = xs_s - HACT;
      else              xs_s = xs_s;
`else
      xs_s = xk_s;
`endif
      pix_s[24*k +: 24] = lane_rgb(xs_s, y_s, mode_r, solid_r);
    end
  end

  // Registered video outputs, one clock behind the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs  <= ~HS_POL;
      vs  <= ~VS_POL;
      de  <= 1'b0;
      rgb <= {(24*PPC){1'b0}};
      sof <= 1'b0;
    end else if (state_r == ST_IDLE) begin
      hs  <= ~HS_POL;
      vs  <= ~VS_POL;
      de  <= 1'b0;
      rgb <= {(24*PPC){1'b0}};
      sof <= 1'b0;
    end else begin
      hs  <= ((h_cnt_r >= HS_ON) && (h_cnt_r < HS_OFF)) ? HS_POL : ~HS_POL;
      vs  <= ((v_cnt_r >= VS_ON) && (v_cnt_r < VS_OFF)) ? VS_POL : ~VS_POL;
      de  <= active_s;
      rgb <= active_s ? pix_s : {(24*PPC){1'b0}};
      sof <= active_s && (h_cnt_r == HB) && (v_cnt_r == VB);
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen on a small raster (HT=80, VT=13), plus a PPC=2 instance.
module tb_pattern_gen;

  localparam int HT = 80;
  localparam int VT = 13;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n, en, en2;
  logic [1:0]  mode, mode2;
  logic [23:0] solid_rgb;
  logic        hs, vs, de, sof, busy;
  logic [23:0] rgb;
  logic        hs2, vs2, de2, sof2, busy2;
  logic [47:0] rgb2;

  always #5 clk = ~clk;

  pattern_gen #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(4), .H_BP(8), .V_ACTIVE(8), .V_FP(1),
                .V_SYNC(2), .V_BP(2), .HS_POL(1'b1), .VS_POL(1'b1), .PPC(1), .CHK_SHIFT(2),
                .CNT_W(13)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .hs(hs), .vs(vs), .de(de), .rgb(rgb), .sof(sof), .busy(busy));

  pattern_gen #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(4), .H_BP(8), .V_ACTIVE(8), .V_FP(1),
                .V_SYNC(2), .V_BP(2), .HS_POL(1'b1), .VS_POL(1'b1), .PPC(2), .CHK_SHIFT(2),
                .CNT_W(13)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .solid_rgb(solid_rgb),
    .hs(hs2), .vs(vs2), .de(de2), .rgb(rgb2), .sof(sof2), .busy(busy2));

  typedef struct packed {
    logic        hs, vs, de, sof, busy;
    logic [23:0] rgb;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          m_st = 0;
  int          m_p = 0;
  int          cur_p = -1;
  logic [1:0]  m_mode = 2'd0;
  logic [23:0] m_solid = 24'h0;
  int          m_off = 0;
  int          m_foff = 0;

  function automatic logic [23:0] pat(input int x, input int y);
    int         xs;
    logic [7:0] g;
    xs = x;
`ifdef SCROLL_EN
    xs = (x + m_foff) % 64;
`endif
    g = xs[7:0];
    case (m_mode)
      2'd0: begin
        case (xs / 8)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      2'd1: return {g, g, g};
      2'd2: return ((((xs >> 2) ^ (y >> 2)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
      default: return m_solid;
    endcase
  endfunction

  // One clock of the reference model: push the output expected after this edge.
  task automatic step();
    exp_t e;
    int   h, v;
    logic last;
    @(posedge clk);
    cyc++;
    e = '0;
    cur_p = -1;
    if (!rst_n) begin
      m_st = 0; m_p = 0; m_off = 0; m_foff = 0; m_mode = 2'd0; m_solid = 24'h0;
    end else if (m_st == 0) begin
      if (en) begin m_st = 1; m_p = 0; end
      e.busy = en;
    end else begin
      h = m_p % HT;
      v = m_p / HT;
      e.hs  = (h >= 4) && (h < 8);
      e.vs  = (v >= 1) && (v < 3);
      e.de  = (h >= 16) && (v >= 5);
      e.sof = (h == 16) && (v == 5);
      e.rgb = e.de ? pat(h - 16, v - 5) : 24'h0;
      cur_p = m_p;
      if (m_st == 1 && m_p == 0) begin
        m_mode = mode; m_solid = solid_rgb; m_foff = m_off; m_off = (m_off + 1) % 64;
      end
      last = (m_p == FT - 1);
      m_st = en ? 1 : (last ? 0 : 2);
      m_p  = (m_p + 1) % FT;
      e.busy = (m_st != 0);
    end
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e, o;
    rst_n = 1'b0; en = 1'b0; en2 = 1'b0; mode = 2'd0; mode2 = 2'd1; solid_rgb = 24'h123456;
    repeat (2) @(negedge clk);
    checks += 6;
    if (hs !== 1'b0)      begin errors++; $display("FAIL reset_hs got %b exp 0", hs); end
    if (vs !== 1'b0)      begin errors++; $display("FAIL reset_vs got %b exp 0", vs); end
    if (de !== 1'b0)      begin errors++; $display("FAIL reset_de got %b exp 0", de); end
    if (rgb !== 24'h0)    begin errors++; $display("FAIL reset_rgb got %h exp 0", rgb); end
    if (sof !== 1'b0)     begin errors++; $display("FAIL reset_sof got %b exp 0", sof); end
    if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); e = sb.pop_front(); o = {hs, vs, de, sof, busy, rgb}; checks++;
      if (o !== e) begin errors++; $display("FAIL reset_idle cyc=%0d got %h exp %h", cyc, o, e); end
    end
  endtask

  task automatic test_timing();
    exp_t        e, o;
    logic [23:0] bars [8];
    logic [23:0] line0 [64];
    int          n_hs = 0, n_vs = 0, n_de = 0, n_sof = 0, prev_sof = -1;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    sb.delete();
    mode = 2'd0; en = 1'b1;
    for (int i = 0; i < 2 * FT + 5; i++) begin
      step(); e = sb.pop_front(); o = {hs, vs, de, sof, busy, rgb}; checks++;
      if (o !== e) begin errors++; $display("FAIL timing cyc=%0d got %h exp %h", cyc, o, e); end
      n_hs += int'(hs); n_vs += int'(vs); n_de += int'(de);
      if (i < FT && cur_p >= 416 && cur_p < 480) line0[cur_p - 416] = rgb;
      if (sof === 1'b1) begin
        n_sof++;
        if (prev_sof >= 0) begin
          checks++;
          if (cyc - prev_sof != FT) begin errors++; $display("FAIL sof_period got %0d exp %0d", cyc - prev_sof, FT); end
        end
        prev_sof = cyc;
      end
    end
    checks += 4;
    if (n_hs != 104)  begin errors++; $display("FAIL hs_count got %0d exp 104", n_hs); end
    if (n_vs != 320)  begin errors++; $display("FAIL vs_count got %0d exp 320", n_vs); end
    if (n_de != 1024) begin errors++; $display("FAIL de_count got %0d exp 1024", n_de); end
    if (n_sof != 2)   begin errors++; $display("FAIL sof_count got %0d exp 2", n_sof); end
`ifndef SCROLL_EN
    for (int x = 0; x < 64; x++) begin
      checks++;
      if (line0[x] !== bars[x / 8]) begin errors++; $display("FAIL colour_bar x=%0d got %h exp %h", x, line0[x], bars[x / 8]); end
    end
`endif
  endtask

  task automatic test_mode_shadow();
    exp_t       e, o;
    int         fr = 0;
    logic [7:0] g;
    for (int i = 0; i < 3 * FT; i++) begin
      if (fr == 0 && cur_p == 500) mode = 2'd1;
      if (fr == 1 && cur_p == 500) mode = 2'd2;
      step(); e = sb.pop_front(); o = {hs, vs, de, sof, busy, rgb}; checks++;
      if (o !== e) begin errors++; $display("FAIL mode_shadow cyc=%0d got %h exp %h", cyc, o, e); end
      if (cur_p == 0) fr++;
`ifndef SCROLL_EN
      if (fr == 1 && cur_p >= 416 && cur_p < 480) begin
        g = 8'(cur_p - 416); checks++;
        if (rgb !== {g, g, g}) begin errors++; $display("FAIL gray_ramp x=%0d got %h exp %h", cur_p - 416, rgb, {g, g, g}); end
      end
      if (fr == 2 && cur_p == 736) begin
        checks++;
        if (rgb !== 24'h000000) begin errors++; $display("FAIL checker_px0 got %h exp 000000", rgb); end
      end
      if (fr == 2 && cur_p == 740) begin
        checks++;
        if (rgb !== 24'hFFFFFF) begin errors++; $display("FAIL checker_px4 got %h exp FFFFFF", rgb); end
      end
`endif
    end
  endtask

  task automatic test_stop();
    exp_t e, o;
    for (int i = 0; i < 2 * FT && cur_p != 250; i++) begin
      step(); e = sb.pop_front(); o = {hs, vs, de, sof, busy, rgb}; checks++;
      if (o !== e) begin errors++; $display("FAIL stop_pre cyc=%0d got %h exp %h", cyc, o, e); end
    end
    checks++;
    if (cur_p != 250) begin errors++; $display("FAIL stop_wait timeout got %0d exp 250", cur_p); end
    en = 1'b0;
    for (int i = 0; i < FT; i++) begin
      step(); e = sb.pop_front(); o = {hs, vs, de, sof, busy, rgb}; checks++;
      if (o !== e) begin errors++; $display("FAIL stop cyc=%0d got %h exp %h", cyc, o, e); end
      if (cur_p == FT - 2) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_before_wrap got %b exp 1", busy); end
      end
      if (cur_p == FT - 1) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_wrap got %b exp 0", busy); end
      end
    end
    checks += 2;
    if (hs !== 1'b0) begin errors++; $display("FAIL stop_idle_hs got %b exp 0", hs); end
    if (vs !== 1'b0) begin errors++; $display("FAIL stop_idle_vs got %b exp 0", vs); end
  endtask

  task automatic test_back_to_back();
    exp_t e, o;
    int   n_sof = 0, prev_sof = -1, n_idle = 0;
    en = 1'b1;
    for (int i = 0; i < 2 * FT && cur_p != 240; i++) begin
      step(); e = sb.pop_front(); o = {hs, vs, de, sof, busy, rgb}; checks++;
      if (o !== e) begin errors++; $display("FAIL b2b_pre cyc=%0d got %h exp %h", cyc, o, e); end
    end
    checks++;
    if (cur_p != 240) begin errors++; $display("FAIL b2b_wait timeout got %0d exp 240", cur_p); end
    en = 1'b0;
    for (int i = 0; i < 2 * FT + 100; i++) begin
      if (i == 100) en = 1'b1;
      step(); e = sb.pop_front(); o = {hs, vs, de, sof, busy, rgb}; checks++;
      if (o !== e) begin errors++; $display("FAIL b2b cyc=%0d got %h exp %h", cyc, o, e); end
      if (busy !== 1'b1) n_idle++;
      if (sof === 1'b1) begin
        n_sof++;
        if (prev_sof >= 0) begin
          checks++;
          if (cyc - prev_sof != FT) begin errors++; $display("FAIL b2b_sof_period got %0d exp %0d", cyc - prev_sof, FT); end
        end
        prev_sof = cyc;
      end
    end
    checks += 2;
    if (n_idle != 0) begin errors++; $display("FAIL b2b_busy_gap got %0d exp 0", n_idle); end
    if (n_sof != 2)  begin errors++; $display("FAIL b2b_sof_count got %0d exp 2", n_sof); end
  endtask

  task automatic test_reset_mid();
    exp_t e, o;
    int   first_sof = -1;
    for (int i = 0; i < 2 * FT && !(m_st != 0 && m_p == 6 * HT + 40); i++) begin
      step(); e = sb.pop_front(); o = {hs, vs, de, sof, busy, rgb}; checks++;
      if (o !== e) begin errors++; $display("FAIL rstmid_pre cyc=%0d got %h exp %h", cyc, o, e); end
    end
    checks++;
    if (m_p != 6 * HT + 40) begin errors++; $display("FAIL rstmid_wait timeout got %0d exp %0d", m_p, 6 * HT + 40); end
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (hs !== 1'b0)   begin errors++; $display("FAIL rstmid_hs got %b exp 0", hs); end
    if (de !== 1'b0)   begin errors++; $display("FAIL rstmid_de got %b exp 0", de); end
    if (rgb !== 24'h0) begin errors++; $display("FAIL rstmid_rgb got %h exp 0", rgb); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    step(); e = sb.pop_front(); o = {hs, vs, de, sof, busy, rgb}; checks++;
    if (o !== e) begin errors++; $display("FAIL rstmid_hold got %h exp %h", o, e); end
    rst_n = 1'b1;
    for (int k = 1; k <= 1100; k++) begin
      step(); e = sb.pop_front(); o = {hs, vs, de, sof, busy, rgb}; checks++;
      if (o !== e) begin errors++; $display("FAIL rstmid cyc=%0d got %h exp %h", cyc, o, e); end
      if (sof === 1'b1 && first_sof < 0) first_sof = k;
    end
    checks++;
    if (first_sof != 418) begin errors++; $display("FAIL rstmid_first_sof got %0d exp 418", first_sof); end
  endtask

  task automatic test_ppc2();
    exp_t       e, o;
    int         n = 0, n_hs = 0, n_sof = 0, n_lines = 0;
    logic [7:0] g0, g1;
    en2 = 1'b1;
    for (int i = 0; i < 523; i++) begin
      step(); e = sb.pop_front(); o = {hs, vs, de, sof, busy, rgb}; checks++;
      if (o !== e) begin errors++; $display("FAIL ppc2_main cyc=%0d got %h exp %h", cyc, o, e); end
      n_hs += int'(hs2); n_sof += int'(sof2);
      if (de2 === 1'b1) begin
        g0 = 8'(2 * n); g1 = 8'(2 * n + 1); checks++;
        if (rgb2 !== {g1, g1, g1, g0, g0, g0}) begin
          errors++; $display("FAIL ppc2_lanes n=%0d got %h exp %h", n, rgb2, {g1, g1, g1, g0, g0, g0});
        end
        n++;
      end else if (n > 0) begin
        checks++; n_lines++;
        if (n != 32) begin errors++; $display("FAIL ppc2_de_len got %0d exp 32", n); end
        n = 0;
      end
    end
    checks += 3;
    if (n_hs != 26)   begin errors++; $display("FAIL ppc2_hs_count got %0d exp 26", n_hs); end
    if (n_sof != 1)   begin errors++; $display("FAIL ppc2_sof_count got %0d exp 1", n_sof); end
    if (n_lines != 8) begin errors++; $display("FAIL ppc2_lines got %0d exp 8", n_lines); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_mode_shadow();
    test_stop();
    test_back_to_back();
    test_reset_mid();
    test_ppc2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
